// File: rtl/dram_req_responder_if.sv
// dram_req_responder_if: word request bus plus half-word SDRAM controller port of the DRAM responder.
interface dram_req_responder_if #(parameter int ADDR_BITS = 16);
    logic [ADDR_BITS-1:0] req_addr;
    logic                 req_read_en;
    logic                 req_write_en;
    logic [3:0]           req_byte_enable;
    logic [31:0]          req_write_data;
    logic                 req_ack;
    logic [31:0]          req_read_data;
    logic                 busy;
    logic                 req_overrun;
    logic                 mc_cmd_valid;
    logic                 mc_cmd_ready;
    logic                 mc_cmd_write;
    logic [ADDR_BITS:0]   mc_cmd_addr;
    logic [15:0]          mc_cmd_wdata;
    logic [1:0]           mc_cmd_be;
    logic                 mc_rdata_valid;
    logic [15:0]          mc_rdata;
    modport master (
        output req_addr, req_read_en, req_write_en, req_byte_enable, req_write_data,
        output mc_cmd_ready, mc_rdata_valid, mc_rdata,
        input  req_ack, req_read_data, busy, req_overrun,
        input  mc_cmd_valid, mc_cmd_write, mc_cmd_addr, mc_cmd_wdata, mc_cmd_be
    );
    modport slave (
        input  req_addr, req_read_en, req_write_en, req_byte_enable, req_write_data,
        input  mc_cmd_ready, mc_rdata_valid, mc_rdata,
        output req_ack, req_read_data, busy, req_overrun,
        output mc_cmd_valid, mc_cmd_write, mc_cmd_addr, mc_cmd_wdata, mc_cmd_be
    );
endinterface

// File: rtl/dram_req_responder.sv
// dram_req_responder: splits one 32-bit DRAM request into 16-bit controller commands and acks it once.
module dram_req_responder #(
    parameter int ADDR_BITS = 16
) (
    input logic           clk,
    input logic           reset_n,
    dram_req_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD_LO, CMD_HI, WAIT_RD, ACK} state_t;
    state_t               state;
    logic [ADDR_BITS-1:0] addr_r;
    logic [3:0]           be_r;
    logic [31:0]          wd_r;
    logic                 wr_r;
    logic [1:0]           beats;
    logic [15:0]          lo_r;
    logic                 ack_r;
    logic                 valid_r;
    logic                 write_r;
    logic [ADDR_BITS:0]   caddr_r;
    logic [15:0]          cwdata_r;
    logic [1:0]           cbe_r;
    logic [31:0]          rdata_r;
    logic                 ovr_r;
    logic                 req;
    logic                 acc;
    logic                 done;

    assign req  = bus.req_read_en | bus.req_write_en;
    assign acc  = valid_r & bus.mc_cmd_ready;
    // Read completes once both beats are in, including the beat arriving this very cycle.
    assign done = !wr_r && (beats == 2'd2 || (bus.mc_rdata_valid && beats == 2'd1));

    assign bus.req_ack       = ack_r;
    assign bus.req_read_data = rdata_r;
    assign bus.busy          = (state != IDLE) | req;
    assign bus.req_overrun   = ovr_r;
    assign bus.mc_cmd_valid  = valid_r;
    assign bus.mc_cmd_write  = write_r;
    assign bus.mc_cmd_addr   = caddr_r;
    assign bus.mc_cmd_wdata  = cwdata_r;
    assign bus.mc_cmd_be     = cbe_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_r   <= '0;
            be_r     <= '0;
            wd_r     <= '0;
            wr_r     <= 1'b0;
            beats    <= '0;
            lo_r     <= '0;
            ack_r    <= 1'b0;
            valid_r  <= 1'b0;
            write_r  <= 1'b0;
            caddr_r  <= '0;
            cwdata_r <= '0;
            cbe_r    <= '0;
            rdata_r  <= '0;
            ovr_r    <= 1'b0;
        end else begin
            if (req && state != IDLE)
                ovr_r <= 1'b1;
            if (state != IDLE && !wr_r && bus.mc_rdata_valid && beats != 2'd2) begin
                beats <= beats + 2'd1;
                if (beats == 2'd0)
                    lo_r <= bus.mc_rdata;
                else
                    rdata_r <= {bus.mc_rdata, lo_r};
            end
            case (state)
                IDLE: if (req) begin
                    addr_r  <= bus.req_addr;
                    be_r    <= bus.req_byte_enable;
                    wd_r    <= bus.req_write_data;
                    wr_r    <= bus.req_write_en;
                    write_r <= bus.req_write_en;
                    beats   <= '0;
                    if (bus.req_read_en && bus.req_write_en)
                        ovr_r <= 1'b1;
                    if (!bus.req_write_en || bus.req_byte_enable[1:0] != 2'b00) begin
                        state    <= CMD_LO;
                        valid_r  <= 1'b1;
                        caddr_r  <= {bus.req_addr, 1'b0};
                        cwdata_r <= bus.req_write_data[15:0];
                        cbe_r    <= bus.req_write_en ? bus.req_byte_enable[1:0] : 2'b11;
                    end else if (bus.req_byte_enable[3:2] != 2'b00) begin
                        state    <= CMD_HI;
                        valid_r  <= 1'b1;
                        caddr_r  <= {bus.req_addr, 1'b1};
                        cwdata_r <= bus.req_write_data[31:16];
                        cbe_r    <= bus.req_byte_enable[3:2];
                    end else begin
                        state <= ACK;
                        ack_r <= 1'b1;
                    end
                end
                CMD_LO: if (acc) begin
                    if (!wr_r || be_r[3:2] != 2'b00) begin
                        state    <= CMD_HI;
                        caddr_r  <= {addr_r, 1'b1};
                        cwdata_r <= wd_r[31:16];
                        cbe_r    <= wr_r ? be_r[3:2] : 2'b11;
                    end else begin
                        state   <= ACK;
                        valid_r <= 1'b0;
                        ack_r   <= 1'b1;
                    end
                end
                CMD_HI: if (acc) begin
                    valid_r <= 1'b0;
                    state   <= (wr_r || done) ? ACK : WAIT_RD;
                    ack_r   <= wr_r || done;
                end
                WAIT_RD: if (done) begin
                    state <= ACK;
                    ack_r <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                    ack_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dram_req_responder.md
Name: dram_req_responder

Overview:
- Target-side responder for the single-word DRAM request interface (addr/read_en/write_en/byte_enable/write_data in; ack/read_data out) issued by the DRAM r/w buffer.
- Accepts one 32-bit request at a time and splits it into 16-bit half-word commands for the narrow SDRAM controller port.
- Reassembles read data from the controller and returns exactly one ack pulse per accepted request.

Parameters:
- ADDR_BITS, `MEM_ADDR_BITS, width of the word address on the request side.
- DATA_BITS, `XLEN (32), request data width; fixed to 2 x 16-bit beats.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_addr  in  ADDR_BITS  word address, sampled on a request pulse
- req_read_en  in  1  one-cycle read request pulse
- req_write_en  in  1  one-cycle write request pulse
- req_byte_enable  in  4  byte lanes, sampled with a write
- req_write_data  in  32  write data, sampled with a write
- req_ack  out  1  one-cycle completion pulse
- req_read_data  out  32  assembled read word, valid from the ack cycle until the next read ack
- busy  out  1  high from the request cycle through the ack cycle
- req_overrun  out  1  sticky flag: request dropped (arrived while busy, or read_en and write_en asserted together); cleared only by reset
- mc_cmd_valid  out  1  half-word command valid
- mc_cmd_ready  in  1  controller accepts the command when valid and ready are both high
- mc_cmd_write  out  1  1 = write, 0 = read
- mc_cmd_addr  out  ADDR_BITS+1  half-word address {req_addr, beat}
- mc_cmd_wdata  out  16  write half-word
- mc_cmd_be  out  2  half-word byte enables
- mc_rdata_valid  in  1  read beat return, in command order
- mc_rdata  in  16  read beat data

Behaviour:
- Reset: all outputs 0; state IDLE; captured address, data and byte-enable registers cleared.
- Request capture, IDLE only:
  - When req_read_en or req_write_en is high, latch addr, be, wdata and direction; busy goes high in the same cycle (combinational from the pulse).
  - If both enables are high: treat as a write and set req_overrun.
  - Any request pulse in a non-IDLE state is dropped and sets req_overrun.
- States: IDLE, CMD_LO, CMD_HI, WAIT_RD, ACK.
- Write, low beat:
  - If be[1:0] != 0, enter CMD_LO: mc_cmd_valid=1, addr {a,0}, wdata wd[15:0], be be[1:0]. Hold all command fields stable until ready.
  - If be[1:0] == 0, skip to the high-beat decision.
- Write, high beat:
  - If be[3:2] != 0, enter CMD_HI: addr {a,1}, wdata wd[31:16], be be[3:2].
  - Otherwise go to ACK.
- Write with be=0000: IDLE -> ACK directly. No mc commands are issued; ack pulses on the cycle after the request.
- Read:
  - CMD_LO then CMD_HI are always issued, mc_cmd_be=11, with no wait for data between the two commands; then WAIT_RD.
  - A beat counter (0..2) counts mc_rdata_valid in every non-IDLE state, so data returning during CMD_HI is captured.
  - First beat goes to rd[15:0], second beat to rd[31:16].
  - On the second beat, req_read_data updates and the FSM goes to ACK on the next edge.
- ACK: req_ack=1 for exactly one cycle, busy=1 in that cycle; then IDLE. busy drops the cycle after ack.
- Latency with ready tied high and read data returned the cycle after each command:
  - write of 1111: ack on the 3rd cycle after the request.
  - read: ack on the 1 cycle after the second beat returns.
- mc_cmd_valid is never withdrawn before acceptance; stalls of any length on mc_cmd_ready are tolerated.
- mc_rdata_valid in IDLE (stray, or left over from before a reset) is ignored, with no state change.
- Reset mid-operation: abort immediately, no ack issued, return to IDLE; req_overrun cleared.
- req_read_data is unchanged by write transactions.

Test Plan:
- Write a=0x10, be=1111, wd=0xA5A55A5A, ready=1 -> commands (0x20,0x5A5A,be=11) then (0x21,0xA5A5,be=11); single ack; no overrun.
- Write be=1100, wd=0x12345678 -> only command (addr {a,1}, 0x1234, be=11); write be=0000 -> ack the next cycle, zero commands.
- Read a=0x3, ready stalled low for 5 cycles on each command, beats 0xBEEF then 0xDEAD -> mc_cmd fields stable during the stall; req_read_data=0xDEADBEEF at the ack.
- Read with the first beat returned during CMD_HI -> correct assembly, exactly one ack.
- Second request pulse while busy, plus a separate read_en+write_en pulse -> dropped request produces no command; both-high is executed as a write; req_overrun=1 and stays set.
- reset_n low while in WAIT_RD, followed by a stray mc_rdata_valid -> all outputs 0, state IDLE, no ack; a following read completes normally.
